// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: sizing helpers and the
// state encoding used by the output feature-map writer.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int out_size(input int fm, input int k, input int p, input int s);
        return ((fm - k + 2 * p) / s) + 1;
    endfunction

endpackage

// File: rtl/maxpool_2x2_line.sv
// 2x2 stride-2 signed max pooling over a raster stream: a hold register for
// the left beat of each pair and a line buffer of pair maxima from the even row.
module maxpool_2x2_line
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 48,
    parameter int LB_DEPTH   = 2,
    parameter int IDX_W      = 1
) (
    input  logic                         i_clk,
    input  logic                         i_valid,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    input  logic                         i_row_odd,
    input  logic                         i_col_odd,
    input  logic [IDX_W-1:0]             i_idx,
    output logic                         o_valid,
    output logic signed [DATA_WIDTH-1:0] o_data
);

    logic signed [DATA_WIDTH-1:0] h_q;
    logic signed [DATA_WIDTH-1:0] lb_q [LB_DEPTH];
    logic signed [DATA_WIDTH-1:0] pair_max;
    logic signed [DATA_WIDTH-1:0] lb_rd;

    always_comb begin
        lb_rd    = lb_q[i_idx];
        pair_max = (h_q > i_data) ? h_q : i_data;
        o_valid  = i_valid && i_row_odd && i_col_odd;
        o_data   = (lb_rd > pair_max) ? lb_rd : pair_max;
    end

    // NOTE: the line buffer and hold register carry no reset; every entry is
    // written before it is read, and an unreset array maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (i_valid && !i_col_odd) begin
            h_q <= i_data;
        end
        if (i_valid && i_col_odd && !i_row_odd) begin
            lb_q[i_idx] <= pair_max;
        end
    end

endmodule

// File: rtl/ofm_writer.sv
// Output feature-map writer: turns the raster result stream into addressed
// BRAM writes, with optional 2x2 max pooling, and reports done/overflow.
module ofm_writer
    import conv_pkg::*;
#(
    parameter int FM_SIZE     = 252,
    parameter int KERNEL_SIZE = 3,
    parameter int PADDING     = 0,
    parameter int STRIDE      = 1,
    parameter int MAXPOOL     = 0,
    parameter int DATA_WIDTH  = 48,
    localparam int OUT_SIZE   = out_size(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE),
    localparam int WR_SIZE    = (MAXPOOL != 0) ? OUT_SIZE / 2 : OUT_SIZE,
    localparam int ADDR_WIDTH = max_int(1, clog2(WR_SIZE * WR_SIZE))
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_en,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    output logic                         o_wr_en,
    output logic [ADDR_WIDTH-1:0]        o_wr_addr,
    output logic signed [DATA_WIDTH-1:0] o_wr_data,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_overflow
);

    localparam int              CNT_W = max_int(1, clog2(OUT_SIZE));
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_SIZE - 1);

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             row_q, col_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic                         accept, stray, last_beat;
    logic                         wr_fire;
    logic signed [DATA_WIDTH-1:0] wr_value;

    // A start pulse wins over a coincident beat: it is neither stored nor flagged.
    assign accept    = (state_q == ST_COLLECT) && i_en && !i_start;
    assign stray     = (state_q != ST_COLLECT) && i_en && !i_start;
    assign last_beat = accept && (row_q == LAST) && (col_q == LAST);

    // NOTE: next-state is assigned its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (i_start) state_d = ST_COLLECT;
            ST_COLLECT: if (i_start) state_d = ST_COLLECT;
                        else if (last_beat) state_d = ST_DONE;
            ST_DONE:    if (i_start) state_d = ST_COLLECT;
            default:    state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_start) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            if (col_q == LAST) begin
                col_q <= '0;
                row_q <= (row_q == LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    generate
        if (MAXPOOL != 0) begin : g_pool
            localparam int               LB_DEPTH  = max_int(1, OUT_SIZE / 2);
            localparam int               IDX_W     = max_int(1, clog2(LB_DEPTH));
            localparam logic [CNT_W-1:0] POOL_LAST = CNT_W'(2 * WR_SIZE - 1);

            // With an odd side the trailing row and column fall outside every window.
            logic             in_window;
            logic [IDX_W-1:0] idx;
            assign in_window = accept && (row_q <= POOL_LAST) && (col_q <= POOL_LAST);
            assign idx       = IDX_W'(col_q >> 1);

            maxpool_2x2_line #(
                .DATA_WIDTH(DATA_WIDTH),
                .LB_DEPTH  (LB_DEPTH),
                .IDX_W     (IDX_W)
            ) u_pool (
                .i_clk    (i_clk),
                .i_valid  (in_window),
                .i_data   (i_data),
                .i_row_odd(row_q[0]),
                .i_col_odd(col_q[0]),
                .i_idx    (idx),
                .o_valid  (wr_fire),
                .o_data   (wr_value)
            );
        end else begin : g_pass
            assign wr_fire  = accept;
            assign wr_value = i_data;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_overflow <= 1'b0;
            addr_q     <= '0;
        end else begin
            o_wr_en <= wr_fire;
            if (wr_fire) begin
                o_wr_addr <= addr_q;
                o_wr_data <= wr_value;
            end
            if (i_start)      addr_q <= '0;
            else if (wr_fire) addr_q <= addr_q + 1'b1;
            if (i_start)      o_overflow <= 1'b0;
            else if (stray)   o_overflow <= 1'b1;
        end
    end

    assign o_busy = (state_q == ST_COLLECT);
    assign o_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_ofm_writer.sv
// Self-checking bench: three writer configurations share one stimulus stream
// and are compared every cycle against a raster/window reference model.
module tb_ofm_writer;

    localparam int DW = 48;
    localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, start, en;
    logic signed [DW-1:0] din;

    logic a_we, a_busy, a_done, a_ovf;
    logic b_we, b_busy, b_done, b_ovf;
    logic c_we, c_busy, c_done, c_ovf;
    logic [3:0] a_addr;
    logic [1:0] b_addr, c_addr;
    logic signed [DW-1:0] a_data, b_data, c_data;

    ofm_writer #(.FM_SIZE(6), .KERNEL_SIZE(3), .PADDING(0), .STRIDE(1), .MAXPOOL(0), .DATA_WIDTH(DW)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_en(en), .i_data(din),
        .o_wr_en(a_we), .o_wr_addr(a_addr), .o_wr_data(a_data),
        .o_busy(a_busy), .o_done(a_done), .o_overflow(a_ovf));

    ofm_writer #(.FM_SIZE(6), .KERNEL_SIZE(3), .PADDING(0), .STRIDE(1), .MAXPOOL(1), .DATA_WIDTH(DW)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_en(en), .i_data(din),
        .o_wr_en(b_we), .o_wr_addr(b_addr), .o_wr_data(b_data),
        .o_busy(b_busy), .o_done(b_done), .o_overflow(b_ovf));

    ofm_writer #(.FM_SIZE(7), .KERNEL_SIZE(3), .PADDING(0), .STRIDE(1), .MAXPOOL(1), .DATA_WIDTH(DW)) u_c (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_en(en), .i_data(din),
        .o_wr_en(c_we), .o_wr_addr(c_addr), .o_wr_data(c_data),
        .o_busy(c_busy), .o_done(c_done), .o_overflow(c_ovf));

    typedef struct {
        int                   addr;
        logic signed [63:0]   data;
    } wr_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, one slot per configuration.
    int  n_of  [3] = '{4, 4, 5};
    int  mp_of [3] = '{0, 1, 1};
    string nm  [3] = '{"A", "B", "C"};
    int  phase [3];
    int  cnt   [3];
    bit  ovf   [3];
    bit  e_we  [3];
    bit  chk_ad[3];
    int  e_addr[3];
    logic signed [DW-1:0] e_data[3];
    logic signed [DW-1:0] grid[3][5][5];

    wr_t log_b[$];
    int  c_writes = 0;
    bit  a_done15 = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y);
        return (x > y) ? x : y;
    endfunction

    function automatic logic signed [DW-1:0] rnd48();
        logic [47:0] v;
        v = {16'($urandom), 32'($urandom)};
        return $signed(v);
    endfunction

    task automatic model(input bit r, input bit s, input bit e, input logic signed [DW-1:0] d);
        for (int m = 0; m < 3; m++) begin
            e_we[m]   = 1'b0;
            chk_ad[m] = 1'b0;
            if (r) begin
                phase[m] = 0; cnt[m] = 0; ovf[m] = 1'b0;
                chk_ad[m] = 1'b1; e_addr[m] = 0; e_data[m] = '0;
            end else if (s) begin
                phase[m] = 1; cnt[m] = 0; ovf[m] = 1'b0;
            end else if (e) begin
                if (phase[m] != 1) begin
                    ovf[m] = 1'b1;
                end else begin
                    int nn, rr, cc, w;
                    nn = n_of[m];
                    rr = cnt[m] / nn;
                    cc = cnt[m] % nn;
                    w  = (mp_of[m] != 0) ? nn / 2 : nn;
                    grid[m][rr][cc] = d;
                    cnt[m]++;
                    if (mp_of[m] == 0) begin
                        e_we[m] = 1'b1; e_addr[m] = cnt[m] - 1; e_data[m] = d;
                    end else if ((rr % 2 == 1) && (cc % 2 == 1) && (rr < 2 * w) && (cc < 2 * w)) begin
                        e_we[m]   = 1'b1;
                        e_addr[m] = (rr / 2) * w + cc / 2;
                        e_data[m] = smax(smax(grid[m][rr-1][cc-1], grid[m][rr-1][cc]),
                                         smax(grid[m][rr][cc-1], d));
                    end
                    if (cnt[m] == nn * nn) phase[m] = 2;
                end
            end
            if (e_we[m]) chk_ad[m] = 1'b1;
        end
    endtask

    // One clock: apply inputs, let the edge pass, then compare every output.
    task automatic step(input bit r, input bit s, input bit e, input logic signed [DW-1:0] d);
        logic act_we[3], act_busy[3], act_done[3], act_ovf[3];
        logic signed [63:0] act_addr[3], act_data[3];
        rst = r; start = s; en = e; din = d;
        @(posedge clk);
        #1;
        model(r, s, e, d);
        act_we   = '{a_we, b_we, c_we};
        act_busy = '{a_busy, b_busy, c_busy};
        act_done = '{a_done, b_done, c_done};
        act_ovf  = '{a_ovf, b_ovf, c_ovf};
        act_addr = '{{60'd0, a_addr}, {62'd0, b_addr}, {62'd0, c_addr}};
        act_data = '{64'(a_data), 64'(b_data), 64'(c_data)};
        for (int m = 0; m < 3; m++) begin
            check({nm[m], ".wr_en"},    64'(act_we[m]),   64'(e_we[m]));
            check({nm[m], ".busy"},     64'(act_busy[m]), 64'(phase[m] == 1));
            check({nm[m], ".done"},     64'(act_done[m]), 64'(phase[m] == 2));
            check({nm[m], ".overflow"}, 64'(act_ovf[m]),  64'(ovf[m]));
            if (chk_ad[m]) begin
                check({nm[m], ".wr_addr"}, act_addr[m], 64'(e_addr[m]));
                check({nm[m], ".wr_data"}, act_data[m], 64'(e_data[m]));
            end
        end
        if (b_we === 1'b1) log_b.push_back('{int'(b_addr), 64'(b_data)});
        if (c_we === 1'b1) c_writes++;
        if (a_we === 1'b1 && a_addr == 4'd15) a_done15 = a_done;
    endtask

    task automatic check_log(input int i, input int addr, input logic signed [63:0] data);
        if (i < log_b.size()) begin
            check($sformatf("B.log%0d.addr", i), 64'(log_b[i].addr), 64'(addr));
            check($sformatf("B.log%0d.data", i), log_b[i].data, data);
        end else begin
            check($sformatf("B.log%0d.present", i), 64'(0), 64'(1));
        end
    endtask

    initial begin
        int exp_addr[4];
        int exp_data[4];
        exp_addr = '{0, 1, 2, 3};
        exp_data = '{5, 7, 13, 15};
        rst = 1'b1; start = 1'b0; en = 1'b0; din = '0;

        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);

        // Back-to-back raster beats with data = beat index.
        log_b.delete();
        step(0, 1, 0, '0);
        for (int k = 0; k < 16; k++) step(0, 0, 1, DW'(k));
        check("A.done_with_addr15", 64'(a_done15), 64'(1));
        for (int k = 16; k < 25; k++) step(0, 0, 1, DW'(k));
        step(0, 0, 0, '0);
        check("A.overflow_after_done", 64'(a_ovf), 64'(1));
        check("B.pool_write_count", 64'(log_b.size()), 64'(4));
        for (int i = 0; i < 4; i++) check_log(i, exp_addr[i], 64'(exp_data[i]));
        check("C.done_after_25", 64'(c_done), 64'(1));

        // Sparse beats with two bubbles between them; restart clears overflow.
        c_writes = 0;
        step(0, 1, 0, '0);
        check("A.overflow_cleared", 64'(a_ovf), 64'(0));
        for (int k = 0; k < 25; k++) begin
            step(0, 0, 1, rnd48());
            step(0, 0, 0, '0);
            step(0, 0, 0, '0);
        end
        check("C.pool_write_count", 64'(c_writes), 64'(4));

        // Signed windows: small negatives, then the most negative value.
        log_b.delete();
        step(0, 1, 0, '0);
        step(0, 0, 1, -48'sd5);
        step(0, 0, 1, -48'sd3);
        step(0, 0, 1, SMIN);
        step(0, 0, 1, SMIN);
        step(0, 0, 1, -48'sd8);
        step(0, 0, 1, -48'sd2);
        step(0, 0, 1, SMIN);
        step(0, 0, 1, SMIN);
        for (int k = 0; k < 8; k++) step(0, 0, 1, rnd48());
        check_log(0, 0, -64'sd2);
        check_log(1, 1, -64'sd140737488355328);

        // Start coincident with a beat, then reset mid-collection.
        step(0, 1, 1, 48'sd99);
        check("A.no_overflow_on_start_en", 64'(a_ovf), 64'(0));
        for (int k = 0; k < 7; k++) step(0, 0, 1, rnd48());
        step(1, 0, 0, '0);
        check("A.idle_after_reset", 64'(a_busy), 64'(0));
        step(0, 0, 1, rnd48());

        // Random traffic with occasional starts and resets.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 79) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 6, rnd48());
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
